curve_engine_sim_bench: RTL and testbench
=========================================

Name: curve_engine_sim_bench

Overview:
- Self-checking simulation harness for the curve-engine field arithmetic.
- Contains a GF(2^255−19) modular add/sub datapath and a fixed vector ROM.
- A sequencer steps through the vectors, compares each result with its expected value, and reports pass/fail through the standard CI status ports (success/done/report).
- Sits directly under the CI testbench top; it is the only DUT.

Parameters:
- NUM_VECTORS, 4: number of ROM vectors executed, 1..4.
- TIMEOUT_CYCLES, 50000: refclk cycles after reset release before a forced done with failure.
- INJECT_FAULT, 0: when 1, bit 0 of vector 0's expected value is inverted before comparison (self-test of the checker).

Ports:
- refclk  input  1  sole clock, 12 MHz nominal.
- rst  input  1  asynchronous, active-low reset. Low clears all state asynchronously; release is sampled on refclk.
- sim_success  output  1  high only when done with zero errors and no timeout.
- sim_done  output  1  sticky completion flag.
- sim_report  output  32  status word: {8'hCE, state[3:0], timeout, 3'b0, vec_idx[7:0], err_cnt[7:0]}.

Behaviour:
- Reset (rst low) values:
  - sim_done=0, sim_success=0.
  - vec_idx=0, err_cnt=0, timeout=0, cycle counter=0, state=IDLE.
  - sim_report=32'hCE00_0000.
- FSM state encodings: IDLE=0, LOAD=1, EXEC=2, CHECK=3, DONE=4.
- Transitions:
  - IDLE→LOAD on the first refclk edge after release.
  - LOAD: latch a, b, op and expected from ROM[vec_idx] → EXEC.
  - EXEC: register the datapath result → CHECK.
  - CHECK: if result≠expected, err_cnt++ (saturating at 255). Then if vec_idx==NUM_VECTORS−1 → DONE, else vec_idx++ → LOAD.
  - DONE: hold forever until reset.
- Latency: 3 cycles per vector. With default parameters, DONE is entered on the 13th rising edge after reset release.
- sim_done is registered and rises on the same edge DONE is entered.
- sim_success = sim_done & (err_cnt==0) & ~timeout, registered together with sim_done.
- Timeout:
  - Free-running counter from reset release.
  - If it reaches TIMEOUT_CYCLES before DONE: set timeout=1, go to DONE, sim_success=0.
  - Counter saturates and does not run after DONE.
- Arithmetic, with p = 2^255−19 = 0x7FFF…FFED and operands < p:
  - op 0 (add): s = a+b computed at 256 bits; if s ≥ p then s−p, else s.
  - op 1 (sub): d = a−b; if a < b then d+p, else d.
  - Result is 255 bits; comparison is over all 255 bits.
- Reset mid-operation: asynchronous clear of everything. The sequence restarts from vector 0 on release.
- sim_report updates every cycle from the live registers. After DONE it is frozen except for reset.

Decomposition:
- Package curve_engine_sim_pkg holds:
  - constant P25519 (255-bit);
  - op enum (OP_ADD=0, OP_SUB=1);
  - vector struct {a, b, op, expected};
  - 4-entry vector ROM constant;
  - state enum.
- ROM contents:
  - V0: 1+2=3.
  - V1: (p−1)+2=1.
  - V2: 3−5=p−2.
  - V3: 0−0=0.
- One sub-module, fe25519_addsub: purely combinational, inputs (a, b, op), output result. The sequencer registers its output in EXEC.

Test Plan:
- Hold rst low for 10 cycles → sim_done=0, sim_success=0, sim_report=32'hCE00_0000 throughout.
- Release rst with defaults:
  - 13th edge after release → sim_done=1, sim_success=1.
  - sim_report=32'hCE40_0300 (state DONE, vec_idx=3, err_cnt=0).
  - Values stay stable for 1000 further cycles.
- INJECT_FAULT=1 → done on edge 13, sim_success=0, err_cnt=1, sim_report=32'hCE40_0301.
- Drive rst low during EXEC of vector 2 (edge 9), then release → all outputs clear immediately. Run repeats and completes 13 edges after the new release with success=1.
- TIMEOUT_CYCLES=5 → done asserted, timeout bit (sim_report[19]) =1, sim_success=0, state field=4.
- Unit test of fe25519_addsub:
  - (p−1)+(p−1) → p−2.
  - 0−1 → p−1.
  - (p−1)−(p−1) → 0.
  - (2^254)+(2^254) → 19.

Source files
------------

// File: rtl/curve_engine_sim_pkg.sv
// rtl/curve_engine_sim_pkg.sv - shared types, constants and vector ROM for the curve-engine harness
//
// Purpose: field modulus, operation and state encodings, the vector record
// layout and the fixed four-entry vector ROM used by the sequencer.
// Ports: none (package).
package curve_engine_sim_pkg;

  // p = 2^255 - 19, i.e. 0x7FFF...FFED truncated to its 255 significant bits.
  localparam logic [254:0] P25519 = {{247{1'b1}}, 8'hED};

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_EXEC  = 4'd2,
    ST_CHECK = 4'd3,
    ST_DONE  = 4'd4
  } state_e;

  typedef struct packed {
    logic [254:0] a;
    logic [254:0] b;
    op_e          op;
    logic [254:0] expected;
  } vector_t;

  localparam vector_t VECTOR_ROM [4] = '{
    '{255'd1,           255'd2, OP_ADD, 255'd3},
    '{P25519 - 255'd1,  255'd2, OP_ADD, 255'd1},
    '{255'd3,           255'd5, OP_SUB, P25519 - 255'd2},
    '{255'd0,           255'd0, OP_SUB, 255'd0}
  };

endpackage

// File: rtl/fe25519_addsub.sv
// rtl/fe25519_addsub.sv - combinational modular add/sub over GF(2^255-19)
//
// Purpose: result = (a + b) mod p for op=0, (a - b) mod p for op=1.
// Operands are assumed already reduced (< p).
// Ports:
//   a, b    in  255  operands
//   op      in  1    0 = add, 1 = sub
//   result  out 255  reduced result
module fe25519_addsub
  import curve_engine_sim_pkg::*;
(
  input  logic [254:0] a,
  input  logic [254:0] b,
  input  logic         op,
  output logic [254:0] result
);

  logic [255:0] sum;
  logic [254:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Wrapping at 2^255 is harmless: adding p back below is also taken
    // modulo 2^255, and the true answer a - b + p always fits.
    diff   = a - b;
    result = '0;
    if (op == OP_SUB) begin
      result = (a < b) ? diff + P25519 : diff;
    end else begin
      // s - p < 2^255, so subtracting on the low 255 bits is exact.
      result = (sum >= {1'b0, P25519}) ? sum[254:0] - P25519 : sum[254:0];
    end
  end

endmodule

// File: rtl/curve_engine_sim_bench.sv
// rtl/curve_engine_sim_bench.sv - self-checking vector sequencer around the field add/sub datapath
//
// Purpose: steps through the vector ROM (LOAD/EXEC/CHECK per vector), counts
// mismatches and reports through the CI status ports; a free-running counter
// forces a failing completion if the run stalls.
// Ports:
//   refclk       in   1   sole clock
//   rst          in   1   asynchronous active-low reset
//   sim_success  out  1   done with zero errors and no timeout
//   sim_done     out  1   sticky completion flag
//   sim_report   out  32  {8'hCE, state, timeout, 3'b0, vec_idx, err_cnt}
module curve_engine_sim_bench
  import curve_engine_sim_pkg::*;
#(
  parameter int NUM_VECTORS    = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int INJECT_FAULT   = 0
) (
  input  logic        refclk,
  input  logic        rst,
  output logic        sim_success,
  output logic        sim_done,
  output logic [31:0] sim_report
);

  localparam logic [7:0]  LAST_IDX      = 8'(NUM_VECTORS - 1);
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_e       state, state_next;
  logic [7:0]   vec_idx, vec_idx_next;
  logic [7:0]   err_cnt, err_cnt_next;
  logic         timeout, timeout_next;
  logic [31:0]  cycle_cnt, cycle_cnt_next;
  logic         done_next, success_next;

  logic [254:0] op_a, op_b, expected, result, dp_result, exp_cmp;
  op_e          op_q;
  vector_t      rom_entry;
  logic         mismatch;

  assign rom_entry = VECTOR_ROM[vec_idx[1:0]];

  // The fault-injection option flips bit 0 of vector 0's reference so the
  // checker itself can be proven to catch a mismatch.
  assign exp_cmp  = expected ^ {254'd0, (INJECT_FAULT != 0) && (vec_idx == 8'd0)};
  assign mismatch = (result != exp_cmp);

  fe25519_addsub u_addsub (
    .a      (op_a),
    .b      (op_b),
    .op     (op_q),
    .result (dp_result)
  );

  // State and datapath registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      vec_idx     <= '0;
      err_cnt     <= '0;
      timeout     <= 1'b0;
      cycle_cnt   <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_q        <= OP_ADD;
      expected    <= '0;
      result      <= '0;
      sim_done    <= 1'b0;
      sim_success <= 1'b0;
    end else begin
      state       <= state_next;
      vec_idx     <= vec_idx_next;
      err_cnt     <= err_cnt_next;
      timeout     <= timeout_next;
      cycle_cnt   <= cycle_cnt_next;
      sim_done    <= done_next;
      sim_success <= success_next;
      if (state == ST_LOAD) begin
        op_a     <= rom_entry.a;
        op_b     <= rom_entry.b;
        op_q     <= rom_entry.op;
        expected <= rom_entry.expected;
      end
      if (state == ST_EXEC) begin
        result <= dp_result;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next     = state;
    vec_idx_next   = vec_idx;
    err_cnt_next   = err_cnt;
    timeout_next   = timeout;
    cycle_cnt_next = cycle_cnt;

    if (state != ST_DONE && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt_next = cycle_cnt + 32'd1;
    end

    case (state)
      ST_IDLE:  state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_CHECK;
      ST_CHECK: begin
        if (mismatch && err_cnt != 8'hFF) begin
          err_cnt_next = err_cnt + 8'd1;
        end
        if (vec_idx == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          vec_idx_next = vec_idx + 8'd1;
          state_next   = ST_LOAD;
        end
      end
      default:  state_next = ST_DONE;
    endcase

    // A normal completion on the same edge wins over the timeout.
    if (state != ST_DONE && state_next != ST_DONE && cycle_cnt_next >= TIMEOUT_LIMIT) begin
      timeout_next = 1'b1;
      state_next   = ST_DONE;
    end
  end

  // Outputs: status flags are registered from these, report is live.
  always_comb begin
    done_next    = (state_next == ST_DONE);
    success_next = done_next && (err_cnt_next == 8'd0) && !timeout_next;
    sim_report   = {8'hCE, state, timeout, 3'b000, vec_idx, err_cnt};
  end

endmodule

// File: tb/tb_curve_engine_sim_bench.sv
// tb/tb_curve_engine_sim_bench.sv - self-checking bench for curve_engine_sim_bench and fe25519_addsub
module tb_curve_engine_sim_bench;

  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  logic        refclk = 1'b0;
  logic        rst_a, rst_b;
  logic        success_a, done_a, success_b, done_b, success_t, done_t;
  logic [31:0] report_a, report_b, report_t;

  logic [254:0] ua, ub, ures;
  logic         uop;

  always #5 refclk = ~refclk;

  curve_engine_sim_bench dut_a (
    .refclk(refclk), .rst(rst_a), .sim_success(success_a), .sim_done(done_a), .sim_report(report_a)
  );

  curve_engine_sim_bench #(.INJECT_FAULT(1)) dut_b (
    .refclk(refclk), .rst(rst_b), .sim_success(success_b), .sim_done(done_b), .sim_report(report_b)
  );

  curve_engine_sim_bench #(.TIMEOUT_CYCLES(5)) dut_t (
    .refclk(refclk), .rst(rst_b), .sim_success(success_t), .sim_done(done_t), .sim_report(report_t)
  );

  fe25519_addsub dut_u (.a(ua), .b(ub), .op(uop), .result(ures));

  int n_checks = 0;
  int n_pass   = 0;

  logic [254:0] exp_q[$];
  logic [31:0]  rep_q[$];

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [254:0] a;
    logic [254:0] b;
    logic         op;
    logic [254:0] exp;
  } tv_t;

  function automatic logic [254:0] model(input logic [254:0] a, input logic [254:0] b, input logic op);
    logic [256:0] wa, wb, wp, r;
    wa = {2'b00, a};
    wb = {2'b00, b};
    wp = {2'b00, P};
    r  = op ? (wa + wp - wb) % wp : (wa + wb) % wp;
    return r[254:0];
  endfunction

  initial begin
    tv_t          tv[8];
    logic [254:0] one;
    logic [255:0] rnd;
    logic [31:0]  exp_rep;
    int           bad;

    one = 255'd1;
    tv[0] = '{P - 255'd1, P - 255'd1, 1'b0, P - 255'd2};
    tv[1] = '{255'd0, 255'd1, 1'b1, P - 255'd1};
    tv[2] = '{P - 255'd1, P - 255'd1, 1'b1, 255'd0};
    tv[3] = '{one << 254, one << 254, 1'b0, 255'd19};
    tv[4] = '{255'd1, 255'd2, 1'b0, 255'd3};
    tv[5] = '{P - 255'd1, 255'd2, 1'b0, 255'd1};
    tv[6] = '{255'd3, 255'd5, 1'b1, P - 255'd2};
    tv[7] = '{255'd0, 255'd0, 1'b1, 255'd0};

    ua = '0; ub = '0; uop = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset held: outputs must stay cleared.
    for (int i = 0; i < 10; i++) begin
      @(negedge refclk);
      check("rst_done", {254'd0, done_a}, 255'd0);
      check("rst_success", {254'd0, success_a}, 255'd0);
      check("rst_report", {223'd0, report_a}, {223'd0, 32'hCE00_0000});
    end

    // Release and run all three sequencer instances.
    rep_q.push_back(32'hCE40_0300);
    rep_q.push_back(32'hCE40_0301);
    rep_q.push_back(32'hCE48_0100);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge refclk);
      #1;
      if (n == 4) check("to_not_done_e4", {254'd0, done_t}, 255'd0);
      if (n == 5) begin
        check("to_done_e5", {254'd0, done_t}, 255'd1);
        check("to_success", {254'd0, success_t}, 255'd0);
        check("to_bit", {254'd0, report_t[19]}, 255'd1);
        check("to_state", {251'd0, report_t[23:20]}, 255'd4);
        exp_rep = rep_q[2];
        check("to_report", {223'd0, report_t}, {223'd0, exp_rep});
      end
      if (n == 12) begin
        check("a_not_done_e12", {254'd0, done_a}, 255'd0);
        check("b_not_done_e12", {254'd0, done_b}, 255'd0);
      end
    end
    check("a_done_e13", {254'd0, done_a}, 255'd1);
    check("a_success", {254'd0, success_a}, 255'd1);
    exp_rep = rep_q.pop_front();
    check("a_report", {223'd0, report_a}, {223'd0, exp_rep});
    check("b_done_e13", {254'd0, done_b}, 255'd1);
    check("b_success", {254'd0, success_b}, 255'd0);
    exp_rep = rep_q.pop_front();
    check("b_report", {223'd0, report_b}, {223'd0, exp_rep});
    exp_rep = rep_q.pop_front();
    check("to_report_hold", {223'd0, report_t}, {223'd0, exp_rep});

    // Completion must be frozen.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge refclk);
      #1;
      if (report_a !== 32'hCE40_0300 || done_a !== 1'b1 || success_a !== 1'b1) bad++;
    end
    check("a_stable_1000", 255'(bad), 255'd0);

    // Reset in the middle of vector 2, then a full rerun.
    @(negedge refclk);
    rst_a = 1'b0;
    @(negedge refclk);
    rst_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge refclk);
      #1;
    end
    check("mid_exec_report", {223'd0, report_a}, {223'd0, 32'hCE20_0200});
    #2;
    rst_a = 1'b0;
    #1;
    check("mid_rst_report", {223'd0, report_a}, {223'd0, 32'hCE00_0000});
    check("mid_rst_done", {254'd0, done_a}, 255'd0);
    @(negedge refclk);
    rst_a = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge refclk);
      #1;
      if (n == 12) check("rerun_not_done_e12", {254'd0, done_a}, 255'd0);
    end
    check("rerun_done", {254'd0, done_a}, 255'd1);
    check("rerun_success", {254'd0, success_a}, 255'd1);
    check("rerun_report", {223'd0, report_a}, {223'd0, 32'hCE40_0300});

    // Datapath unit test: table vectors then random vectors against the model.
    for (int i = 0; i < 8; i++) begin
      ua = tv[i].a; ub = tv[i].b; uop = tv[i].op;
      exp_q.push_back(tv[i].exp);
      #1;
      check($sformatf("addsub_tv%0d", i), ures, exp_q.pop_front());
    end
    for (int i = 0; i < 12; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ua  = rnd[254:0] % P;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ub  = (i < 2) ? ua : rnd[254:0] % P;
      uop = i[0];
      exp_q.push_back(model(ua, ub, uop));
      #1;
      check($sformatf("addsub_rnd%0d", i), ures, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
